ram_march_bist: RTL and testbench

- Built-in self-test controller that sits directly upstream of the synchronous single-port RAM.
- Drives the RAM's we/addr/data_in and consumes its registered data_out.
- Runs a March C- sequence over every address on request, using all-zeros/all-ones backgrounds.
- Reports pass/fail plus first-failure diagnostics; stops on the first mismatch.

---
 rtl/ram_pkg.sv | 30 +++
 rtl/march_addr_gen.sv | 42 ++++
 rtl/ram_march_bist.sv | 177 +++++++++++++++++
 tb/tb_ram_march_bist.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the March C- BIST controller.
//   state_t          - controller FSM states
//   E0..E5           - march element indices
//   ELEM_* tables    - per-element direction, expected read background and
//                      write background, indexed by element number
package ram_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWr0,
        StRdA,
        StWrB,
        StRdOnly,
        StRdLast,
        StDone
    } state_t;

    localparam logic [2:0] E0 = 3'd0;
    localparam logic [2:0] E1 = 3'd1;
    localparam logic [2:0] E2 = 3'd2;
    localparam logic [2:0] E3 = 3'd3;
    localparam logic [2:0] E4 = 3'd4;
    localparam logic [2:0] E5 = 3'd5;

    // Bit e of each table describes element e (1 = ascending / all-ones).
    localparam logic [7:0] ELEM_ASCENDING  = 8'b0000_0111;
    localparam logic [7:0] ELEM_READ_ONES  = 8'b0001_0100;
    localparam logic [7:0] ELEM_WRITE_ONES = 8'b0000_1010;

endpackage

// File: rtl/march_addr_gen.sv
// Up/down address counter for the march sequence.
//   clk, rst    - clock, asynchronous active-high reset
//   load_zero   - load address 0 (highest priority)
//   load_max    - load address N-1
//   step        - advance one address in the selected direction
//   ascending   - counting direction
//   addr        - current address (registered)
//   terminal    - current address is the last one for this direction
module march_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_zero,
    input  logic                  load_max,
    input  logic                  step,
    input  logic                  ascending,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  terminal
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    logic [ADDR_WIDTH-1:0] addr_q;

    assign terminal = ascending ? (addr_q == ADDR_MAX) : (addr_q == '0);
    assign addr     = addr_q;

    // Stepping stops at the terminal address so the counter never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (load_zero) begin
            addr_q <= '0;
        end else if (load_max) begin
            addr_q <= ADDR_MAX;
        end else if (step && !terminal) begin
            addr_q <= ascending ? addr_q + 1'b1 : addr_q - 1'b1;
        end
    end

endmodule

// File: rtl/ram_march_bist.sv
// March C- built-in self-test controller for a synchronous single-port RAM.
//   clk, rst       - clock (shared with the RAM), asynchronous active-high reset
//   start          - one-cycle request to begin a run (ignored while busy)
//   ram_we/addr/wdata - registered RAM controls
//   ram_rdata      - RAM registered read data (one-cycle latency)
//   busy, done     - run in progress / run finished
//   pass           - valid with done, 1 = no mismatch
//   fail_elem/addr/data - diagnostics of the first mismatch
module ram_march_bist
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [2:0]            fail_elem,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data
);

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic                  ram_we_q, ram_we_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  rd_valid_q;
    logic                  pass_q;
    logic [2:0]            fail_elem_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [DATA_WIDTH-1:0] fail_data_q;

    logic load_zero, load_max, step, addr_terminal;
    logic start_accept, cmp_en, mismatch;

    march_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load_zero(load_zero),
        .load_max (load_max),
        .step     (step),
        .ascending(ELEM_ASCENDING[elem_q]),
        .addr     (ram_addr),
        .terminal (addr_terminal)
    );

    assign start_accept = start && (state_q == StIdle || state_q == StDone);
    // In RD_ONLY the first cycle has no returned data yet.
    assign cmp_en   = (state_q == StWrB) || (state_q == StRdLast) ||
                      (state_q == StRdOnly && rd_valid_q);
    assign mismatch = cmp_en && (ram_rdata != {DATA_WIDTH{ELEM_READ_ONES[elem_q]}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        load_zero = 1'b0;
        load_max  = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_accept) begin
                    state_d   = StWr0;
                    elem_d    = E0;
                    load_zero = 1'b1;
                end
            end
            StWr0: begin
                if (addr_terminal) begin
                    state_d   = StRdA;
                    elem_d    = E1;
                    load_zero = 1'b1;
                end else begin
                    step = 1'b1;
                end
            end
            StRdA: state_d = StWrB;
            StWrB: begin
                if (mismatch) begin
                    state_d = StDone;
                end else if (!addr_terminal) begin
                    state_d = StRdA;
                    step    = 1'b1;
                end else begin
                    state_d = StRdA;
                    unique case (elem_q)
                        E1: begin elem_d = E2; load_zero = 1'b1; end
                        E2: begin elem_d = E3; load_max  = 1'b1; end
                        E3: begin elem_d = E4; load_max  = 1'b1; end
                        default: begin
                            elem_d   = E5;
                            load_max = 1'b1;
                            state_d  = StRdOnly;
                        end
                    endcase
                end
            end
            StRdOnly: begin
                if (mismatch) begin
                    state_d = StDone;
                end else if (addr_terminal) begin
                    state_d = StRdLast;
                end else begin
                    step = 1'b1;
                end
            end
            StRdLast: state_d = StDone;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ram_we_d    = (state_d == StWr0) || (state_d == StWrB);
        ram_wdata_d = ram_we_d ? {DATA_WIDTH{ELEM_WRITE_ONES[elem_d]}} : '0;
        busy        = (state_q != StIdle) && (state_q != StDone);
        done        = (state_q == StDone);
        // The write slot paired with a failing read is cancelled so the faulty
        // word is left untouched for post-mortem inspection.
        ram_we      = ram_we_q && !mismatch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_q      <= E0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            rd_addr_q   <= '0;
            rd_valid_q  <= 1'b0;
            pass_q      <= 1'b0;
            fail_elem_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            elem_q      <= elem_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            rd_addr_q   <= ram_addr;
            rd_valid_q  <= (state_q == StRdOnly);
            if (start_accept) begin
                pass_q      <= 1'b0;
                fail_elem_q <= '0;
                fail_addr_q <= '0;
                fail_data_q <= '0;
            end else if (mismatch) begin
                fail_elem_q <= elem_q;
                fail_addr_q <= rd_addr_q;
                fail_data_q <= ram_rdata;
            end else if (state_q == StRdLast) begin
                pass_q <= 1'b1;
            end
        end
    end

    assign ram_wdata = ram_wdata_q;
    assign pass      = pass_q;
    assign fail_elem = fail_elem_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: behavioural 16x8 RAM with optional injected faults,
// scoreboard of expected run results and of the expected RAM access sequence.
module tb_ram_march_bist;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int N = 16;
    localparam int BUDGET = 10 * N + 2;
    localparam int LIMIT = 400;

    logic clk = 1'b0;
    logic rst, start;
    logic ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic busy, done, pass;
    logic [2:0] fail_elem;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;

    always #5 clk = ~clk;

    ram_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .done(done),
        .pass(pass), .fail_elem(fail_elem), .fail_addr(fail_addr), .fail_data(fail_data)
    );

    // RAM model: registered read-before-write; fault_mode 1 = addr 5 bit 3
    // stuck-at-1, fault_mode 2 = write to addr 6 sets addr 7 bit 0.
    logic [DW-1:0] mem [N];
    int fault_mode = 0;
    logic scrub = 1'b0;
    always @(posedge clk) begin
        if (scrub) begin
            for (int i = 0; i < N; i++) mem[i] <= DW'(i * 37 + 5);
        end else begin
            ram_rdata <= mem[ram_addr] | ((fault_mode == 1 && ram_addr == 5) ? 8'h08 : 8'h00);
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                if (fault_mode == 2 && ram_addr == 6) mem[7][0] <= 1'b1;
            end
        end
    end

    // Access monitor: {we, addr} of every RAM cycle while busy, plus write count.
    logic [AW:0] obs_q[$];
    logic [AW:0] exp_ops[$];
    int wr_count = 0;
    always @(posedge clk) begin
        if (!rst) begin
            if (busy) obs_q.push_back({ram_we, ram_addr});
            if (ram_we) wr_count++;
        end
    end

    typedef struct {
        logic          pass;
        logic [2:0]    elem;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cycles;
        int            writes;
    } res_t;
    res_t exp_res[$];

    int n_checks = 0;
    int n_errors = 0;

    // Full fault-free March C- access sequence as the RAM should see it.
    task automatic build_ops();
        exp_ops.delete();
        for (int a = 0; a < N; a++) exp_ops.push_back({1'b1, AW'(a)});
        for (int e = 1; e <= 4; e++) begin
            for (int k = 0; k < N; k++) begin
                int a = (e <= 2) ? k : N - 1 - k;
                exp_ops.push_back({1'b0, AW'(a)});
                exp_ops.push_back({1'b1, AW'(a)});
            end
        end
        for (int k = 0; k < N; k++) exp_ops.push_back({1'b0, AW'(N - 1 - k)});
        // Final compare cycle: the counter holds at address 0, a repeat read.
        exp_ops.push_back({1'b0, AW'(0)});
    endtask

    // Stimulus only: pulse start, optionally re-pulse at given cycles, wait for done.
    task automatic do_run(input int pulse_a, input int pulse_b, output int cycles,
                          output int gaps);
        gaps = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cycles = 1;
        while (!done && cycles < LIMIT) begin
            if (!busy) gaps++;
            start = (cycles == pulse_a || cycles == pulse_b);
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0h want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %0h want 0", done); end
        n_checks++; if (pass !== 1'b0) begin n_errors++; $display("FAIL reset_pass: got %0h want 0", pass); end
        n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %0h want 0", ram_we); end
        n_checks++; if (ram_addr !== '0) begin n_errors++; $display("FAIL reset_addr: got %0h want 0", ram_addr); end
        n_checks++; if (ram_wdata !== '0) begin n_errors++; $display("FAIL reset_wdata: got %0h want 0", ram_wdata); end
        n_checks++; if (fail_elem !== '0) begin n_errors++; $display("FAIL reset_fail_elem: got %0h want 0", fail_elem); end
        n_checks++; if (fail_addr !== '0) begin n_errors++; $display("FAIL reset_fail_addr: got %0h want 0", fail_addr); end
        n_checks++; if (fail_data !== '0) begin n_errors++; $display("FAIL reset_fail_data: got %0h want 0", fail_data); end
        @(negedge clk); rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_wins_start: busy got %0h want 0", busy); end
    endtask

    task automatic test_fault_free(input int pulse_a, input int pulse_b);
        int cycles, gaps, obs_base, wr_base, bad, first_bad, nz;
        res_t e;
        fault_mode = 0;
        @(negedge clk); scrub = 1'b1;
        @(negedge clk); scrub = 1'b0;
        build_ops();
        exp_res.push_back('{1'b1, 3'd0, '0, '0, BUDGET, N + 4 * N});
        obs_base = obs_q.size();
        wr_base = wr_count;
        do_run(pulse_a, pulse_b, cycles, gaps);
        e = exp_res.pop_front();
        n_checks++; if (cycles !== e.cycles) begin n_errors++; $display("FAIL ff_cycles: got %0d want %0d", cycles, e.cycles); end
        n_checks++; if (gaps !== 0) begin n_errors++; $display("FAIL ff_busy_gaps: got %0d want 0", gaps); end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL ff_done_busy: got %0h/%0h want 1/0", done, busy); end
        n_checks++; if (pass !== e.pass) begin n_errors++; $display("FAIL ff_pass: got %0h want %0h", pass, e.pass); end
        n_checks++; if ({fail_elem, fail_addr, fail_data} !== {e.elem, e.addr, e.data}) begin
            n_errors++; $display("FAIL ff_fail_info: got %0h/%0h/%0h want 0/0/0", fail_elem, fail_addr, fail_data);
        end
        n_checks++; if (wr_count - wr_base !== e.writes) begin n_errors++; $display("FAIL ff_writes: got %0d want %0d", wr_count - wr_base, e.writes); end
        n_checks++; if (obs_q.size() - obs_base !== exp_ops.size()) begin
            n_errors++; $display("FAIL ff_op_count: got %0d want %0d", obs_q.size() - obs_base, exp_ops.size());
        end
        bad = 0; first_bad = -1;
        for (int i = 0; i < exp_ops.size() && obs_base + i < obs_q.size(); i++) begin
            if (obs_q[obs_base + i] !== exp_ops[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        n_checks++; if (bad !== 0) begin
            n_errors++; $display("FAIL ff_addr_order: %0d wrong ops, first at %0d got %0h want %0h", bad, first_bad,
                                 obs_q[obs_base + first_bad], exp_ops[first_bad]);
        end
        nz = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== '0) nz++;
        n_checks++; if (nz !== 0) begin n_errors++; $display("FAIL ff_ram_zero: got %0d nonzero words want 0", nz); end
    endtask

    task automatic test_fault(input int mode, input logic [AW-1:0] f_addr, input logic [DW-1:0] f_data,
                              input int exp_cycles, input int exp_writes);
        int cycles, gaps, wr_base;
        res_t e;
        fault_mode = mode;
        exp_res.push_back('{1'b0, 3'd1, f_addr, f_data, exp_cycles, exp_writes});
        wr_base = wr_count;
        do_run(-1, -1, cycles, gaps);
        e = exp_res.pop_front();
        n_checks++; if (cycles !== e.cycles) begin n_errors++; $display("FAIL fault%0d_cycles: got %0d want %0d", mode, cycles, e.cycles); end
        n_checks++; if (done !== 1'b1 || pass !== e.pass) begin n_errors++; $display("FAIL fault%0d_done_pass: got %0h/%0h want 1/0", mode, done, pass); end
        n_checks++; if (fail_elem !== e.elem) begin n_errors++; $display("FAIL fault%0d_elem: got %0h want %0h", mode, fail_elem, e.elem); end
        n_checks++; if (fail_addr !== e.addr) begin n_errors++; $display("FAIL fault%0d_addr: got %0h want %0h", mode, fail_addr, e.addr); end
        n_checks++; if (fail_data !== e.data) begin n_errors++; $display("FAIL fault%0d_data: got %0h want %0h", mode, fail_data, e.data); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (wr_count - wr_base !== e.writes) begin n_errors++; $display("FAIL fault%0d_writes: got %0d want %0d", mode, wr_count - wr_base, e.writes); end
    endtask

    task automatic test_restart_clears();
        int cycles;
        fault_mode = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_checks++; if ({done, pass} !== 2'b00) begin n_errors++; $display("FAIL restart_done_pass: got %0h/%0h want 0/0", done, pass); end
        n_checks++; if ({fail_elem, fail_addr, fail_data} !== '0) begin
            n_errors++; $display("FAIL restart_fail_info: got %0h/%0h/%0h want 0/0/0", fail_elem, fail_addr, fail_data);
        end
        cycles = 1;
        while (!done && cycles < LIMIT) begin @(posedge clk); #1; cycles++; end
        n_checks++; if (cycles !== BUDGET || pass !== 1'b1) begin
            n_errors++; $display("FAIL restart_run: got cycles %0d pass %0h want %0d pass 1", cycles, pass, BUDGET);
        end
    endtask

    task automatic test_reset_mid_run();
        int cycles, gaps;
        res_t e;
        fault_mode = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (79) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++; if ({busy, done, pass, ram_we} !== 4'b0) begin
            n_errors++; $display("FAIL midrst_status: got busy %0h done %0h pass %0h we %0h want 0", busy, done, pass, ram_we);
        end
        n_checks++; if ({ram_addr, ram_wdata, fail_elem, fail_addr, fail_data} !== '0) begin
            n_errors++; $display("FAIL midrst_data: got addr %0h wdata %0h fail %0h/%0h/%0h want 0", ram_addr, ram_wdata,
                                 fail_elem, fail_addr, fail_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if ({busy, done} !== 2'b00) begin n_errors++; $display("FAIL midrst_idle: got busy %0h done %0h want 0/0", busy, done); end
        exp_res.push_back('{1'b1, 3'd0, '0, '0, BUDGET, N + 4 * N});
        do_run(-1, -1, cycles, gaps);
        e = exp_res.pop_front();
        n_checks++; if (cycles !== e.cycles || pass !== e.pass) begin
            n_errors++; $display("FAIL midrst_rerun: got cycles %0d pass %0h want %0d pass 1", cycles, pass, e.cycles);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_fault_free(-1, -1);
        test_fault(1, 4'd5, 8'h08, 29, 21);
        test_fault_free(10, 50);
        test_fault(2, 4'd7, 8'h01, 33, 23);
        test_restart_clears();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
